// File: rtl/fetch_defs_pkg.sv
// Shared constants for the fetch front end: default exception entry, reset text address,
// instruction width and the prefetch queue entry layout {pc, instr}.
package fetch_defs_pkg;

  localparam logic [31:0] KtextPcDefault = 32'h8000_0180;
  localparam logic [31:0] ResetTextPc    = 32'h0040_0000;
  localparam int unsigned InstrW         = 32;

  // Queue entry is {pc, instr}; the instruction occupies the low InstrW bits.
  function automatic int unsigned entry_width(input int unsigned addr_w);
    return addr_w + InstrW;
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO with flush, occupancy count and a registered head entry.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_defs_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 64,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [CntW-1:0]  count_o,
  output logic [Width-1:0] head_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  // Pointer/count next state; flush wins over push and pop.
  always_comb begin
    do_push = push_i & ~flush_i;
    do_pop  = pop_i & ~flush_i & (count_q != '0);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  // Pointer and count registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch front end: PC generator, in-order bus request/response tracking with
// credit-based flow control, stale-response dropping after redirects, and a prefetch queue.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_prefetch_unit
  import fetch_defs_pkg::*;
#(
  parameter int unsigned       QUEUE_DEPTH = 4,
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] KTEXT_PC    = ADDR_W'(KtextPcDefault)
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] iInitialPC,
  output logic              oIReqValid,
  input  logic              iIReqReady,
  output logic [ADDR_W-1:0] oIReqAddr,
  input  logic              iIRspValid,
  input  logic [31:0]       iIRspData,
  input  logic              iRedirect,
  input  logic [ADDR_W-1:0] iRedirectPC,
  input  logic              iException,
  input  logic              iStall,
  output logic              oValid,
  output logic [31:0]       oInstr,
  output logic [ADDR_W-1:0] oPC,
  output logic [ADDR_W-1:0] oPC4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       oPerfFetched,
  output logic [31:0]       oPerfFlushed
`endif
);

  localparam int unsigned CntW   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned EntryW = entry_width(ADDR_W);

  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] rpc_q, rpc_d;
  logic [CntW-1:0]   outst_q, outst_d;
  logic [CntW-1:0]   drop_q, drop_d;
  logic [CntW-1:0]   count;
  logic [EntryW-1:0] head;
  logic [CntW:0]     inflight;
  logic              redirect, credit, req_fire, rsp, push, pop;
  logic [ADDR_W-1:0] target;
  logic              unused_redirect_lsb;

  assign redirect = iRedirect | iException;
  assign target   = iException ? KTEXT_PC : {iRedirectPC[ADDR_W-1:2], 2'b00};
  assign unused_redirect_lsb = ^iRedirectPC[1:0];

  // Queued plus in-flight words may never exceed the queue, so a response always fits.
  assign inflight = {1'b0, count} + {1'b0, outst_q};
  assign credit   = inflight < (CntW + 1)'(QUEUE_DEPTH);
  assign rsp      = iRST & iIRspValid;
  assign req_fire = oIReqValid & iIReqReady;
  assign pop      = oValid & ~iStall;

  // Next state for PCs and bus counters; a redirect overrides push, pop and request.
  always_comb begin
    fpc_d   = fpc_q;
    rpc_d   = rpc_q;
    drop_d  = drop_q;
    push    = 1'b0;
    outst_d = outst_q + CntW'(req_fire) - CntW'(rsp);
    if (redirect) begin
      fpc_d  = target;
      rpc_d  = target;
      // outst already includes earlier stale requests, so every request still out after
      // this cycle belongs to the old path; a response arriving now is discarded too.
      drop_d = outst_q - CntW'(rsp);
    end else begin
      if (req_fire) fpc_d = fpc_q + ADDR_W'(4);
      if (rsp) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CntW'(1);
        end else begin
          push  = 1'b1;
          rpc_d = rpc_q + ADDR_W'(4);
        end
      end
    end
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      fpc_q   <= iInitialPC;
      rpc_q   <= iInitialPC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  fetch_queue #(
    .Depth (QUEUE_DEPTH),
    .Width (EntryW)
  ) u_queue (
    .clk_i   (iCLK),
    .rst_ni  (iRST),
    .flush_i (redirect),
    .push_i  (push),
    .data_i  ({rpc_q, iIRspData}),
    .pop_i   (pop),
    .count_o (count),
    .head_o  (head)
  );

  // Outputs; reset forces the documented idle values regardless of register contents.
  always_comb begin
    oIReqValid = iRST & ~redirect & credit;
    oIReqAddr  = iRST ? fpc_q : iInitialPC;
    oValid     = iRST & (count != '0);
    oInstr     = oValid ? head[InstrW-1:0] : '0;
    oPC        = oValid ? head[EntryW-1:InstrW] : (iRST ? rpc_q : iInitialPC);
    oPC4       = oPC + ADDR_W'(4);
  end

  // The bus may only answer requests it actually accepted.
  assert property (@(posedge iCLK) disable iff (!iRST) iIRspValid |-> outst_q != '0);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] flushed_q, flushed_d;
  logic [31:0] flush_inc;

  // Flushed = queue entries cleared by a redirect plus bus responses thrown away.
  always_comb begin
    flush_inc = '0;
    if (redirect) begin
      flush_inc = 32'(count) + 32'(rsp);
    end else if (rsp && drop_q != '0) begin
      flush_inc = 32'd1;
    end
    fetched_d = sat_add32(fetched_q, 32'(push));
    flushed_d = sat_add32(flushed_q, flush_inc);
  end

  // Saturating performance counter registers.
  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      fetched_q <= '0;
      flushed_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      flushed_q <= flushed_d;
    end
  end

  assign oPerfFetched = fetched_q;
  assign oPerfFlushed = flushed_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a latency-programmable in-order memory model.
module tb_fetch_prefetch_unit;

  logic        clk = 1'b0;
  logic        iRST, iIReqReady, iIRspValid, iRedirect, iException, iStall;
  logic [31:0] iInitialPC, iIRspData, iRedirectPC;
  logic        oIReqValid, oValid;
  logic [31:0] oIReqAddr, oInstr, oPC, oPC4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] oPerfFetched, oPerfFlushed;
`endif

  always #5 clk = ~clk;

  fetch_prefetch_unit dut (
    .iCLK        (clk),
    .iRST        (iRST),
    .iInitialPC  (iInitialPC),
    .oIReqValid  (oIReqValid),
    .iIReqReady  (iIReqReady),
    .oIReqAddr   (oIReqAddr),
    .iIRspValid  (iIRspValid),
    .iIRspData   (iIRspData),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC),
    .iException  (iException),
    .iStall      (iStall),
    .oValid      (oValid),
    .oInstr      (oInstr),
    .oPC         (oPC),
    .oPC4        (oPC4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .oPerfFetched (oPerfFetched),
    .oPerfFlushed (oPerfFlushed)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat    = 1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_instr[$];

  logic        t_req_valid, t_fire, t_valid;
  logic [31:0] t_addr, t_pc, t_pc4, t_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: drive the bus response, sample outputs mid-cycle, log requests/pops.
  task automatic tick();
    cyc++;
    if (!iRST) begin
      pend_addr.delete();
      pend_due.delete();
      iIRspValid = 1'b1;
      iIRspData  = 32'hDEAD_BEEF;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      iIRspValid = 1'b1;
      iIRspData  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      iIRspValid = 1'b0;
      iIRspData  = '0;
    end
    @(negedge clk);
    t_req_valid = oIReqValid;
    t_fire      = oIReqValid && iIReqReady;
    t_addr      = oIReqAddr;
    t_valid     = oValid;
    t_pc        = oPC;
    t_pc4       = oPC4;
    t_instr     = oInstr;
    if (t_fire && iRST) begin
      pend_addr.push_back(t_addr);
      pend_due.push_back(cyc + lat);
    end
    if (oValid && !iStall) begin
      pop_pc.push_back(oPC);
      pop_instr.push_back(oInstr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    iRST = 1'b0; iRedirect = 1'b0; iException = 1'b0; iStall = 1'b0;
    iInitialPC = 32'h0040_0000;
    tick();
    tick();
    iRST = 1'b1;
    pop_pc.delete();
    pop_instr.delete();
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    iInitialPC = 32'hFFFF_FFFC;
    tick();
    checks++;
    if (t_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL reset_addr_wrap: got %h, expected %h", t_addr, 32'hFFFF_FFFC);
    end
    checks++;
    if (t_pc4 !== 32'h0000_0000) begin
      errors++; $display("FAIL reset_pc4_wrap: got %h, expected %h", t_pc4, 32'h0);
    end
    iInitialPC = 32'h0040_0000;
    tick();
    checks++;
    if (t_req_valid !== 1'b0) begin
      errors++; $display("FAIL reset_req_valid: got %b, expected 0", t_req_valid);
    end
    checks++;
    if (t_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b, expected 0", t_valid);
    end
    checks++;
    if (t_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL reset_addr: got %h, expected %h", t_addr, 32'h0040_0000);
    end
    checks++;
    if (t_instr !== 32'h0) begin
      errors++; $display("FAIL reset_instr: got %h, expected 0", t_instr);
    end
    checks++;
    if (t_pc !== 32'h0040_0000 || t_pc4 !== 32'h0040_0004) begin
      errors++; $display("FAIL reset_pc: got %h/%h, expected 00400000/00400004", t_pc, t_pc4);
    end
  endtask

  task automatic test_stream();
    lat = 1;
    iRST = 1'b1;
    iStall = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (!t_fire || t_addr !== 32'h0040_0000 + 32'(4 * (k - 1))) begin
        errors++;
        $display("FAIL stream_req[%0d]: got fire=%b addr=%h, expected fire=1 addr=%h", k,
                 t_fire, t_addr, 32'h0040_0000 + 32'(4 * (k - 1)));
      end
      checks++;
      if (k < 3) begin
        if (t_valid !== 1'b0) begin
          errors++; $display("FAIL stream_early_valid[%0d]: got %b, expected 0", k, t_valid);
        end
      end else if (t_valid !== 1'b1 || t_pc !== 32'h0040_0000 + 32'(4 * (k - 3)) ||
                   t_instr !== mem_word(32'h0040_0000 + 32'(4 * (k - 3))) ||
                   t_pc4 !== 32'h0040_0004 + 32'(4 * (k - 3))) begin
        errors++;
        $display("FAIL stream_out[%0d]: got v=%b pc=%h pc4=%h instr=%h, expected pc=%h", k,
                 t_valid, t_pc, t_pc4, t_instr, 32'h0040_0000 + 32'(4 * (k - 3)));
      end
    end
  endtask

  // Stall with a slow bus, then check that draining yields a contiguous, lossless stream.
  task automatic stall_and_drain(input string name, input int latency, input int nstall);
    int nreq;
    do_reset();
    lat = latency;
    iStall = 1'b1;
    nreq = 0;
    for (int i = 0; i < nstall; i++) begin
      tick();
      if (t_fire) nreq++;
    end
    checks++;
    if (nreq != 4) begin
      errors++; $display("FAIL %s_credit: got %0d requests, expected 4", name, nreq);
    end
    checks++;
    if (t_valid !== 1'b1 || t_pc !== 32'h0040_0000 || t_instr !== mem_word(32'h0040_0000)) begin
      errors++;
      $display("FAIL %s_hold: got v=%b pc=%h instr=%h, expected pc=00400000", name, t_valid,
               t_pc, t_instr);
    end
    iStall = 1'b0;
    pop_pc.delete();
    pop_instr.delete();
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (pop_pc.size() < 8) begin
      errors++; $display("FAIL %s_drain_count: got %0d pops, expected >= 8", name, pop_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (pop_pc[i] !== 32'h0040_0000 + 32'(4 * i) ||
            pop_instr[i] !== mem_word(32'h0040_0000 + 32'(4 * i))) begin
          errors++;
          $display("FAIL %s_order[%0d]: got pc=%h instr=%h, expected pc=%h", name, i,
                   pop_pc[i], pop_instr[i], 32'h0040_0000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_stall();
    stall_and_drain("stall", 3, 10);
  endtask

  task automatic test_full_push_pop();
    stall_and_drain("full", 1, 8);
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 3;
    tick();
    tick();
    iRedirect = 1'b1;
    iRedirectPC = 32'h0040_0103;
    tick();
    checks++;
    if (t_req_valid !== 1'b0) begin
      errors++; $display("FAIL redir_no_req: got %b, expected 0", t_req_valid);
    end
    iRedirect = 1'b0;
    tick();
    checks++;
    if (!t_fire || t_addr !== 32'h0040_0100) begin
      errors++; $display("FAIL redir_first_req: got fire=%b addr=%h, expected 00400100", t_fire,
                         t_addr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (t_valid !== 1'b0) begin
        errors++; $display("FAIL redir_stale[%0d]: got valid=%b pc=%h, expected 0", i, t_valid,
                           t_pc);
      end
    end
    tick();
    checks++;
    if (t_valid !== 1'b1 || t_pc !== 32'h0040_0100 || t_instr !== mem_word(32'h0040_0100)) begin
      errors++; $display("FAIL redir_first_out: got v=%b pc=%h instr=%h, expected pc=00400100",
                         t_valid, t_pc, t_instr);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    lat = 3;
    tick();
    tick();
    iRedirect = 1'b1;
    iRedirectPC = 32'h0040_0200;
    tick();
    iRedirectPC = 32'h0040_0300;
    tick();
    iRedirect = 1'b0;
    tick();
    checks++;
    if (!t_fire || t_addr !== 32'h0040_0300 || t_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_req: got fire=%b addr=%h v=%b, expected 00400300 v=0", t_fire,
                         t_addr, t_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (t_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_stale[%0d]: got valid=%b pc=%h, expected 0", i, t_valid, t_pc);
      end
    end
    tick();
    checks++;
    if (t_valid !== 1'b1 || t_pc !== 32'h0040_0300) begin
      errors++; $display("FAIL b2b_out: got v=%b pc=%h, expected pc=00400300", t_valid, t_pc);
    end
  endtask

  task automatic test_exception();
    do_reset();
    lat = 1;
    for (int i = 0; i < 5; i++) tick();
    iRedirect = 1'b1;
    iException = 1'b1;
    iRedirectPC = 32'h0040_0200;
    tick();
    checks++;
    if (t_req_valid !== 1'b0) begin
      errors++; $display("FAIL exc_no_req: got %b, expected 0", t_req_valid);
    end
    iRedirect = 1'b0;
    iException = 1'b0;
    tick();
    checks++;
    if (t_valid !== 1'b0 || !t_fire || t_addr !== 32'h8000_0180) begin
      errors++; $display("FAIL exc_target: got v=%b fire=%b addr=%h, expected v=0 addr=80000180",
                         t_valid, t_fire, t_addr);
    end
    tick();
    tick();
    checks++;
    if (t_valid !== 1'b1 || t_pc !== 32'h8000_0180 || t_pc4 !== 32'h8000_0184) begin
      errors++; $display("FAIL exc_out: got v=%b pc=%h pc4=%h, expected 80000180/80000184",
                         t_valid, t_pc, t_pc4);
    end
  endtask

  task automatic test_reset_mid();
    int nreq;
    do_reset();
    lat = 3;
    iStall = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    iRST = 1'b0;
    tick();
    checks++;
    if (t_valid !== 1'b0 || t_req_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_in_reset: got v=%b req=%b, expected 0/0", t_valid,
                         t_req_valid);
    end
    iRST = 1'b1;
    tick();
    checks++;
    if (t_valid !== 1'b0 || !t_fire || t_addr !== 32'h0040_0000) begin
      errors++; $display("FAIL midrst_restart: got v=%b fire=%b addr=%h, expected v=0 00400000",
                         t_valid, t_fire, t_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (oPerfFetched !== 32'h0 || oPerfFlushed !== 32'h0) begin
      errors++; $display("FAIL midrst_perf: got %h/%h, expected 0/0", oPerfFetched, oPerfFlushed);
    end
`endif
    nreq = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (t_fire) nreq++;
    end
    checks++;
    if (nreq != 4) begin
      errors++; $display("FAIL midrst_outst: got %0d requests, expected 4", nreq);
    end
    iStall = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iRST = 1'b0; iIReqReady = 1'b1; iIRspValid = 1'b0; iIRspData = '0;
    iRedirect = 1'b0; iException = 1'b0; iStall = 1'b0;
    iInitialPC = 32'h0040_0000; iRedirectPC = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_exception();
    test_full_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
